// File: rtl/i2c_ad7991_responder_pkg.sv
// Shared state encoding, reset configuration and read-word field layout
// for the AD7991-style I2C responder.
package i2c_ad7991_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    localparam logic [7:0] DEFAULT_CFG  = 8'h10;
    localparam int         CFG_MASK_LSB = 4;
    localparam int         B0_CHAN_LSB  = 4;
    localparam int         B0_DATA_LSB  = 0;

    function automatic logic [7:0] make_byte0(input logic [1:0] chan, input logic [3:0] data_hi);
        logic [7:0] b;
        b = 8'h00;
        b[B0_CHAN_LSB +: 2] = chan;
        b[B0_DATA_LSB +: 4] = data_hi;
        return b;
    endfunction

    // Lowest enabled channel above prev (any channel when first), else wrap to the lowest enabled.
    function automatic logic [1:0] next_chan(input logic [3:0] en, input logic first, input logic [1:0] prev);
        logic [3:0] mask;
        logic [1:0] res;
        mask = (en == 4'd0) ? 4'b0001 : en;
        res  = 2'd0;
        for (int i = 3; i >= 0; i--) if (mask[i]) res = 2'(i);
        for (int i = 3; i >= 0; i--) if (mask[i] && (first || (2'(i) > prev))) res = 2'(i);
        return res;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus FILT_LEN-sample glitch filter for one I2C line,
// with single-cycle edge strobes derived from the filtered level.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0]          sync_q;
    logic [FILT_LEN-1:0] hist_q;
    logic                level_q;
    logic                prev_q;

    // The level only moves once FILT_LEN consecutive synchronized samples agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            hist_q  <= '1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_i};
            hist_q <= {hist_q[FILT_LEN-2:0], sync_q[1]};
            if (&hist_q) begin
                level_q <= 1'b1;
            end else if (~|hist_q) begin
                level_q <= 1'b0;
            end
            prev_q <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_ad7991_responder.sv
// I2C target emulating an AD7991: a one-byte write sets the config register,
// reads stream 2-byte conversion words cycling through the enabled channels.
module i2c_ad7991_responder
    import i2c_ad7991_responder_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h28,
    parameter int         FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [11:0] ch0_data,
    input  logic [11:0] ch1_data,
    input  logic [11:0] ch2_data,
    input  logic [11:0] ch3_data,
    output logic [7:0]  cfg,
    output logic        cfg_wr,
    output logic        word_done
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .rst(rst), .line_i(scl_i),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .rst(rst), .line_i(sda_i),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    state_t      state_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  tx_q;
    logic        rw_q, byte_sel_q, ack_q, first_q;
    logic [1:0]  chan_q;
    logic [7:0]  data_lo_q;
    logic        sda_oe_q, cfg_wr_q, word_done_q;
    logic [7:0]  cfg_q;

    logic        start_det, stop_det, load_d, new_word_d;
    logic [1:0]  chan_d;
    logic [11:0] data_d;
    logic [7:0]  tx_byte_d;

    assign start_det  = sda_fall & scl_lvl;
    assign stop_det   = sda_rise & scl_lvl;
    assign chan_d     = next_chan(cfg_q[CFG_MASK_LSB +: 4], first_q, chan_q);
    assign new_word_d = !((state_q == RD_ACK) && !byte_sel_q);
    assign load_d     = scl_fall && (((state_q == ADDR_ACK) && rw_q) || ((state_q == RD_ACK) && ack_q));

    always_comb begin
        data_d = ch0_data;
        case (chan_d)
            2'd1:    data_d = ch1_data;
            2'd2:    data_d = ch2_data;
            2'd3:    data_d = ch3_data;
            default: data_d = ch0_data;
        endcase
        tx_byte_d = new_word_d ? make_byte0(chan_d, data_d[11:8]) : data_lo_q;
    end

    // Bits are sampled on filtered SCL rise; SDA drive only changes right after a filtered SCL fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            rw_q        <= 1'b0;
            byte_sel_q  <= 1'b0;
            ack_q       <= 1'b0;
            first_q     <= 1'b1;
            chan_q      <= 2'd0;
            data_lo_q   <= 8'h00;
            sda_oe_q    <= 1'b0;
            cfg_q       <= DEFAULT_CFG;
            cfg_wr_q    <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            cfg_wr_q    <= 1'b0;
            word_done_q <= 1'b0;
            if (stop_det) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
                first_q  <= 1'b1;
            end else if (start_det) begin
                state_q   <= ADDR;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            shift_q   <= {shift_q[6:0], sda_lvl};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= 4'd0;
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_q  <= ADDR_ACK;
                                rw_q     <= shift_q[0];
                                sda_oe_q <= 1'b1;
                            end else begin
                                state_q  <= IGNORE;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall && !rw_q) begin
                            state_q   <= WR_BYTE;
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= 4'd0;
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            shift_q   <= {shift_q[6:0], sda_lvl};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                cfg_q    <= {shift_q[6:0], sda_lvl};
                                cfg_wr_q <= 1'b1;
                                first_q  <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            state_q  <= WR_ACK;
                            sda_oe_q <= 1'b1;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            state_q   <= WR_BYTE;
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= 4'd0;
                        end
                    end
                    RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                state_q  <= RD_ACK;
                                sda_oe_q <= 1'b0;
                            end else begin
                                sda_oe_q  <= ~tx_q[7];
                                tx_q      <= {tx_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ack_q       <= ~sda_lvl;
                            word_done_q <= byte_sel_q;
                        end else if (scl_fall && !ack_q) begin
                            state_q  <= IGNORE;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase

                if (load_d) begin
                    state_q    <= RD_BYTE;
                    sda_oe_q   <= ~tx_byte_d[7];
                    tx_q       <= {tx_byte_d[6:0], 1'b0};
                    bit_cnt_q  <= 4'd1;
                    byte_sel_q <= !new_word_d;
                    if (new_word_d) begin
                        chan_q    <= chan_d;
                        first_q   <= 1'b0;
                        data_lo_q <= data_d[7:0];
                    end
                end
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign cfg       = cfg_q;
    assign cfg_wr    = cfg_wr_q;
    assign word_done = word_done_q;

endmodule

// File: tb/tb_i2c_ad7991_responder.sv
// Bench for the AD7991 responder: an I2C master task set plus a transaction-level
// model of config, channel rotation and expected SDA drive on every sampled bit.
module tb_i2c_ad7991_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclM, sdaM;
    logic        sdaOe;
    logic [11:0] ch0Data, ch1Data, ch2Data, ch3Data;
    logic [7:0]  cfgOut;
    logic        cfgWr, wordDone;
    wire         sdaBus = sdaM & ~sdaOe;

    always #5 clk = ~clk;

    i2c_ad7991_responder #(.DEV_ADDR(7'h28), .FILT_LEN(3)) dut (
        .clk(clk), .rst(rst), .scl_i(sclM), .sda_i(sdaBus), .sda_oe(sdaOe),
        .ch0_data(ch0Data), .ch1_data(ch1Data), .ch2_data(ch2Data), .ch3_data(ch3Data),
        .cfg(cfgOut), .cfg_wr(cfgWr), .word_done(wordDone)
    );

    int          checks = 0, failures = 0;
    int          cfgWrCount = 0, wordDoneCount = 0;
    int          mCfgWr = 0, mWordDone = 0, mPrev = -1, mByteIdx = 0;
    logic [7:0]  mCfg = 8'h10;
    logic [11:0] mData = 12'h000;
    logic        mActive = 1'b0;
    logic        expOe = 1'b0;
    logic        glitchOn = 1'b0;
    event        sampleEv;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // At every master sample point the responder drive and config must match the model.
    always begin
        @(sampleEv);
        checkOutput("sda_oe at sample", sdaOe, expOe);
        checkOutput("cfg at sample", cfgOut, mCfg);
    end

    always @(negedge clk) begin
        if (cfgWr === 1'b1) cfgWrCount++;
        if (wordDone === 1'b1) wordDoneCount++;
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [11:0] chValue(input int c);
        case (c)
            1:       return ch1Data;
            2:       return ch2Data;
            3:       return ch3Data;
            default: return ch0Data;
        endcase
    endfunction

    function automatic int modelNextChan();
        logic [3:0] mask;
        mask = (mCfg[7:4] == 4'd0) ? 4'b0001 : mCfg[7:4];
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (mPrev + 4 + k) % 4;
            if (mask[c]) return c;
        end
        return 0;
    endfunction

    // One SCL period of 40 clocks starting and ending with SCL low.
    task automatic bitCycle(input logic drv, input logic expOeBit, output logic seen);
        waitClk(5);
        sdaM = drv;
        if (glitchOn) begin
            waitClk(6); sclM = 1'b1; waitClk(1); sclM = 1'b0; waitClk(8);
        end else begin
            waitClk(15);
        end
        sclM = 1'b1;
        if (glitchOn) begin
            waitClk(4); sclM = 1'b0; waitClk(1); sclM = 1'b1; waitClk(5);
        end else begin
            waitClk(10);
        end
        seen  = sdaBus;
        expOe = expOeBit;
        ->sampleEv;
        waitClk(10);
        sclM = 1'b0;
    endtask

    task automatic busStart();
        sdaM = 1'b1; sclM = 1'b1; waitClk(20);
        sdaM = 1'b0; waitClk(20);
        sclM = 1'b0;
    endtask

    task automatic busStop();
        waitClk(5); sdaM = 1'b0; waitClk(15);
        sclM = 1'b1; waitClk(20);
        sdaM = 1'b1; waitClk(20);
        mPrev = -1; mByteIdx = 0; mActive = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic expAck, input logic isCfg, output logic ackSeen);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && isCfg) begin
                mCfg = b; mPrev = -1; mCfgWr++;
            end
            bitCycle(b[i], 1'b0, seen);
        end
        bitCycle(1'b1, expAck, ackSeen);
    endtask

    task automatic sendAddr(input logic [7:0] a, output logic ackSeen);
        mActive  = (a[7:1] == 7'h28);
        mByteIdx = 0;
        sendByte(a, mActive, 1'b0, ackSeen);
    endtask

    task automatic readByte(input logic masterAck, output logic [7:0] got);
        logic [7:0] expB;
        logic       seen;
        int         c;
        if (mByteIdx % 2 == 0) begin
            c     = modelNextChan();
            mPrev = c;
            mData = chValue(c);
            expB  = {2'b00, 2'(c), mData[11:8]};
        end else begin
            expB = mData[7:0];
        end
        for (int i = 7; i >= 0; i--) begin
            bitCycle(1'b1, ~expB[i], seen);
            got[i] = seen;
        end
        bitCycle(~masterAck, 1'b0, seen);
        if (mByteIdx % 2 == 1) mWordDone++;
        mByteIdx++;
    endtask

    task automatic applyStimulus();
        logic       ack, seen;
        logic [7:0] b;
        logic [7:0] wrapExp [6] = '{8'h1A, 8'hBC, 8'h37, 8'h77, 8'h1A, 8'hBC};
        logic [7:0] ch1Exp  [4] = '{8'h1A, 8'hBC, 8'h1A, 8'hBC};

        // Config write 0x30.
        busStart(); sendAddr(8'h50, ack); checkOutput("write addr ack", ack, 1'b0);
        sendByte(8'h30, mActive, mActive, ack); checkOutput("write data ack", ack, 1'b0);
        busStop();
        checkOutput("cfg after write", cfgOut, 8'h30);
        checkOutput("cfg_wr pulses", cfgWrCount, 1);

        // Four-byte read over ch0/ch1; ch0 changes mid-word to prove the snapshot.
        busStart(); sendAddr(8'h51, ack); checkOutput("read addr ack", ack, 1'b0);
        readByte(1'b1, b); checkOutput("read b0", b, 8'h01);
        ch0Data = 12'hFFF;
        readByte(1'b1, b); checkOutput("read b1", b, 8'h23);
        readByte(1'b1, b); checkOutput("read b2", b, 8'h1A);
        readByte(1'b0, b); checkOutput("read b3", b, 8'hBC);
        busStop();
        ch0Data = 12'h123;
        checkOutput("word_done pulses", wordDoneCount, 2);

        // Foreign address is ignored through the STOP.
        busStart(); sendAddr(8'h52, ack); checkOutput("foreign addr nack", ack, 1'b1);
        sendByte(8'h77, 1'b0, 1'b0, ack); checkOutput("foreign data nack", ack, 1'b1);
        busStop();
        checkOutput("cfg untouched", cfgOut, 8'h30);

        // NACK after byte0, then a new read restarts at the lowest enabled channel.
        busStart(); sendAddr(8'h51, ack); readByte(1'b0, b); checkOutput("nack b0", b, 8'h01);
        busStop();
        busStart(); sendAddr(8'h51, ack);
        readByte(1'b1, b); checkOutput("restart b0", b, 8'h01);
        readByte(1'b0, b); checkOutput("restart b1", b, 8'h23);
        busStop();

        // Mask ch1+ch3 wraps back to ch1.
        busStart(); sendAddr(8'h50, ack); sendByte(8'hA0, mActive, mActive, ack); busStop();
        busStart(); sendAddr(8'h51, ack);
        for (int i = 0; i < 6; i++) begin
            readByte(i != 5, b); checkOutput("wrap byte", b, wrapExp[i]);
        end
        busStop();

        // Two data bytes in one write; the last one wins.
        busStart(); sendAddr(8'h50, ack);
        sendByte(8'hF0, mActive, mActive, ack); sendByte(8'h20, mActive, mActive, ack);
        busStop();
        checkOutput("cfg after 2 writes", cfgOut, 8'h20);
        busStart(); sendAddr(8'h51, ack);
        for (int i = 0; i < 4; i++) begin
            readByte(i != 3, b); checkOutput("ch1-only byte", b, ch1Exp[i]);
        end
        busStop();

        // Reset while driving byte1 bit 4.
        ch1Data = 12'h20F;
        busStart(); sendAddr(8'h51, ack);
        readByte(1'b1, b); checkOutput("pre-rst b0", b, 8'h12);
        for (int i = 7; i >= 5; i--) bitCycle(1'b1, ~mData[i], seen);
        waitClk(10);
        checkOutput("oe driving bit4", sdaOe, 1'b1);
        rst = 1'b1; waitClk(1);
        checkOutput("oe after rst", sdaOe, 1'b0);
        checkOutput("cfg after rst", cfgOut, 8'h10);
        rst = 1'b0;
        mCfg = 8'h10;
        waitClk(10); busStop();
        busStart(); sendAddr(8'h51, ack); readByte(1'b0, b); checkOutput("post-rst b0", b, 8'h01);
        busStop();

        // SCL glitches in both phases must not add bits.
        glitchOn = 1'b1;
        busStart(); sendAddr(8'h51, ack); checkOutput("glitch addr ack", ack, 1'b0);
        readByte(1'b1, b); checkOutput("glitch b0", b, 8'h01);
        readByte(1'b0, b); checkOutput("glitch b1", b, 8'h23);
        glitchOn = 1'b0;
        busStop();

        checkOutput("cfg_wr total model", cfgWrCount, mCfgWr);
        checkOutput("cfg_wr total", cfgWrCount, 4);
        checkOutput("word_done total model", wordDoneCount, mWordDone);
        checkOutput("word_done total", wordDoneCount, 9);
    endtask

    initial begin
        rst = 1'b1; sclM = 1'b1; sdaM = 1'b1;
        ch0Data = 12'h123; ch1Data = 12'hABC; ch2Data = 12'h555; ch3Data = 12'h777;
        waitClk(5);
        checkOutput("reset sda_oe", sdaOe, 1'b0);
        checkOutput("reset cfg", cfgOut, 8'h10);
        checkOutput("reset cfg_wr", cfgWr, 1'b0);
        checkOutput("reset word_done", wordDone, 1'b0);
        rst = 1'b0;
        waitClk(10);
        applyStimulus();
        waitClk(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
